// File: rtl/spart_echo_driver_if.sv
// SPART I/O register bus between the echo driver (master) and the SPART (slave).
// One access = one cycle with iocs_n low, no back-pressure on the bus itself.
// The only flow control is the two queue flags: the master may read while rx_q_empty is low
// and write while tx_q_full is low, and it acts on the flag values seen at the clock edge.
interface spart_echo_driver_if;
  logic       iocs_n;
  logic       iorw_n;
  logic [1:0] ioaddr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       tx_q_full;
  logic       rx_q_empty;

  modport master (
    output iocs_n, iorw_n, ioaddr, io_wdata,
    input  io_rdata, tx_q_full, rx_q_empty
  );

  modport slave (
    input  iocs_n, iorw_n, ioaddr, io_wdata,
    output io_rdata, tx_q_full, rx_q_empty
  );
endinterface

// File: rtl/spart_echo_driver.sv
// CPU-less SPART bring-up engine: programs the baud divisor, then echoes every received byte
// back to the TX queue (optionally ASCII case-swapped), holding at most one byte at a time.
module spart_echo_driver #(
  parameter logic [15:0] DIVISOR   = 16'd325,
  parameter bit          CASE_SWAP = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spart_echo_driver_if.master        bus,
  output logic                       init_done,
  output logic [15:0]                echo_cnt,
  output logic [7:0]                 last_byte,
  output logic [2:0]                 state_dbg_o
);

  typedef enum logic [2:0] {
    INIT_DBL = 3'd0,
    INIT_DBH = 3'd1,
    IDLE     = 3'd2,
    RD_RX    = 3'd3,
    WAIT_TX  = 3'd4,
    WR_TX    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q;
  logic [7:0]  hold_q, hold_d;
  logic        cs_n_q, cs_n_d;
  logic        rw_n_q, rw_n_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        init_done_q, init_done_d;
  logic [15:0] echo_cnt_q, echo_cnt_d;
  logic [7:0]  last_byte_q, last_byte_d;

  function automatic logic [7:0] swap_case(input logic [7:0] b);
    if (CASE_SWAP && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    if (CASE_SWAP && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
    return b;
  endfunction

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    init_done_d = init_done_q;
    echo_cnt_d  = echo_cnt_q;
    last_byte_d = last_byte_q;
    cs_n_d      = 1'b1;
    rw_n_d      = 1'b1;
    addr_d      = 2'b00;
    wdata_d     = 8'h00;

    // The first cycle after reset keeps the bus idle and only arms the INIT_DBL access.
    if (!armed_q) begin
      state_d = INIT_DBL;
    end else begin
      case (state_q)
        INIT_DBL: state_d = INIT_DBH;
        INIT_DBH: begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
        IDLE:     if (!bus.rx_q_empty) state_d = RD_RX;
        RD_RX: begin
          hold_d  = swap_case(bus.io_rdata);
          state_d = WAIT_TX;
        end
        WAIT_TX:  if (!bus.tx_q_full) state_d = WR_TX;
        WR_TX: begin
          echo_cnt_d  = echo_cnt_q + 16'd1;
          last_byte_d = hold_q;
          state_d     = bus.rx_q_empty ? IDLE : RD_RX;
        end
        default:  state_d = INIT_DBL;
      endcase
    end

    // Bus registers are loaded from the state being entered, so the access lines up with it.
    case (state_d)
      INIT_DBL: begin
        cs_n_d  = 1'b0;
        rw_n_d  = 1'b0;
        addr_d  = 2'b10;
        wdata_d = DIVISOR[7:0];
      end
      INIT_DBH: begin
        cs_n_d  = 1'b0;
        rw_n_d  = 1'b0;
        addr_d  = 2'b11;
        wdata_d = DIVISOR[15:8];
      end
      RD_RX: begin
        cs_n_d = 1'b0;
        rw_n_d = 1'b1;
      end
      WR_TX: begin
        cs_n_d  = 1'b0;
        rw_n_d  = 1'b0;
        wdata_d = hold_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_DBL;
      armed_q     <= 1'b0;
      hold_q      <= 8'h00;
      cs_n_q      <= 1'b1;
      rw_n_q      <= 1'b1;
      addr_q      <= 2'b00;
      wdata_q     <= 8'h00;
      init_done_q <= 1'b0;
      echo_cnt_q  <= 16'h0000;
      last_byte_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      hold_q      <= hold_d;
      cs_n_q      <= cs_n_d;
      rw_n_q      <= rw_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
      echo_cnt_q  <= echo_cnt_d;
      last_byte_q <= last_byte_d;
    end
  end

  assign bus.iocs_n   = cs_n_q;
  assign bus.iorw_n   = rw_n_q;
  assign bus.ioaddr   = addr_q;
  assign bus.io_wdata = wdata_q;
  assign init_done    = init_done_q;
  assign echo_cnt     = echo_cnt_q;
  assign last_byte    = last_byte_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_spart_echo_driver.sv
// Bench for spart_echo_driver: two instances (plain echo and case-swap) share one SPART queue model;
// a monitor scoreboards every bus access against expected byte queues.
module tb_spart_echo_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_q_full;
  logic        rx_q_empty;
  logic [7:0]  io_rdata;
  logic        init_done0, init_done1;
  logic [15:0] echo_cnt0, echo_cnt1;
  logic [7:0]  last0, last1;
  logic [2:0]  st0, st1;

  spart_echo_driver_if bus0 ();
  spart_echo_driver_if bus1 ();

  assign bus0.io_rdata   = io_rdata;
  assign bus0.tx_q_full  = tx_q_full;
  assign bus0.rx_q_empty = rx_q_empty;
  assign bus1.io_rdata   = io_rdata;
  assign bus1.tx_q_full  = tx_q_full;
  assign bus1.rx_q_empty = rx_q_empty;

  spart_echo_driver #(.DIVISOR(16'd325), .CASE_SWAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .init_done(init_done0), .echo_cnt(echo_cnt0), .last_byte(last0), .state_dbg_o(st0)
  );

  spart_echo_driver #(.DIVISOR(16'd325), .CASE_SWAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .init_done(init_done1), .echo_cnt(echo_cnt1), .last_byte(last1), .state_dbg_o(st1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pushed = 0;
  int rd_count = 0, wr_count = 0;
  int last_rd_cyc = 0, last_wr_cyc = 0, fall_cyc = 0;
  bit held = 1'b0, rd_pend = 1'b0;
  logic tx_full_s = 1'b0, rx_empty_s = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int wr_cyc_q[$];

  typedef struct {
    logic [7:0] in_b;
    logic [7:0] exp_sw;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] swap_ref(input logic [7:0] b);
    int c;
    c = int'(b);
    if (c >= 97 && c <= 122) return 8'(c - 32);
    if (c >= 65 && c <= 90)  return 8'(c + 32);
    return b;
  endfunction

  always @(posedge clk) begin
    cyc++;
    tx_full_s  = tx_q_full;
    rx_empty_s = rx_q_empty;
  end

  // SPART model and scoreboard: bus outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      held    = 1'b0;
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        void'(rx_q.pop_front());
        rd_pend = 1'b0;
      end
      check("bus_sync", 32'({bus1.iocs_n, bus1.iorw_n, bus1.ioaddr}),
            32'({bus0.iocs_n, bus0.iorw_n, bus0.ioaddr}));
      if (bus0.iocs_n) begin
        check("idle_bus", 32'({bus0.iorw_n, bus0.ioaddr, bus0.io_wdata}), 32'({1'b1, 2'b00, 8'h00}));
      end else if (bus0.iorw_n) begin
        check("rd_addr", 32'(bus0.ioaddr), 32'd0);
        check("rd_allowed", 32'({rx_empty_s, held}), 32'd0);
        held = 1'b1;
        rd_pend = 1'b1;
        rd_count++;
        last_rd_cyc = cyc;
      end else if (bus0.ioaddr == 2'b00) begin
        check("wr_allowed", 32'({tx_full_s, held}), 32'd1);
        check("wr_expected", 32'(exp_q0.size() > 0 && exp_q1.size() > 0), 32'd1);
        if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
          check("wr_data_plain", 32'(bus0.io_wdata), 32'(exp_q0.pop_front()));
          check("wr_data_swap", 32'(bus1.io_wdata), 32'(exp_q1.pop_front()));
        end
        held = 1'b0;
        wr_count++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
      end else begin
        check("init_wr_only", 32'({bus0.ioaddr[1], init_done0}), 32'b10);
      end
    end
    io_rdata = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    if (rx_q_empty && rx_q.size() != 0) fall_cyc = cyc;
    rx_q_empty = (rx_q.size() == 0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [7:0] e_sw);
    rx_q.push_back(b);
    exp_q0.push_back(b);
    exp_q1.push_back(e_sw);
    n_pushed++;
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(wr_count >= target), 32'd1);
  endtask

  task automatic wait_reads(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rd_count < target && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(rd_count >= target), 32'd1);
  endtask

  task automatic check_init();
    step();
    check("init_dbl", 32'({bus0.iocs_n, bus0.iorw_n, bus0.ioaddr, bus0.io_wdata}), 32'({4'b0010, 8'h45}));
    check("init_dbl_swapdut", 32'(bus1.io_wdata), 32'h45);
    check("init_done_early", 32'(init_done0), 32'd0);
    step();
    check("init_dbh", 32'({bus0.iocs_n, bus0.iorw_n, bus0.ioaddr, bus0.io_wdata}), 32'({4'b0011, 8'h01}));
    check("init_dbh_swapdut", 32'(bus1.io_wdata), 32'h01);
    check("init_done_dbh", 32'(init_done0), 32'd0);
    step();
    check("init_done", 32'({init_done0, init_done1}), 32'b11);
    check("init_idle", 32'(bus0.iocs_n), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int wr_b, rd_b;

    tbl[0]  = '{8'h61, 8'h41};
    tbl[1]  = '{8'h5A, 8'h7A};
    tbl[2]  = '{8'h31, 8'h31};
    tbl[3]  = '{8'h40, 8'h40};
    tbl[4]  = '{8'h41, 8'h61};
    tbl[5]  = '{8'h5B, 8'h5B};
    tbl[6]  = '{8'h60, 8'h60};
    tbl[7]  = '{8'h7A, 8'h5A};
    tbl[8]  = '{8'h7B, 8'h7B};
    tbl[9]  = '{8'h00, 8'h00};
    tbl[10] = '{8'hFF, 8'hFF};
    tbl[11] = '{8'hE1, 8'hE1};

    rst_n      = 1'b1;
    tx_q_full  = 1'b0;
    rx_q_empty = 1'b1;
    io_rdata   = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_bus", 32'({bus0.iocs_n, bus0.iorw_n, bus0.ioaddr, bus0.io_wdata}), 32'({4'b1100, 8'h00}));
    check("rst_bus_swapdut", 32'({bus1.iocs_n, bus1.iorw_n, bus1.ioaddr, bus1.io_wdata}), 32'({4'b1100, 8'h00}));
    check("rst_outs", 32'({init_done0, echo_cnt0, last0}), 32'd0);
    rst_n = 1'b1;
    check_init();
    repeat (4) step();
    check("idle_cnt", 32'(echo_cnt0), 32'd0);

    // Single echo with latency
    push_byte(8'h41, 8'h61);
    wait_writes(1, 20, "echo1_done");
    check("lat_rd", 32'(last_rd_cyc - fall_cyc), 32'd1);
    check("lat_wr", 32'(last_wr_cyc - last_rd_cyc), 32'd2);
    step();
    check("echo1_cnt", 32'({echo_cnt0, echo_cnt1}), 32'({16'd1, 16'd1}));
    check("echo1_last", 32'({last0, last1}), 32'({8'h41, 8'h61}));

    // TX back-pressure
    tx_q_full = 1'b1;
    push_byte(8'h5A, 8'h7A);
    wait_reads(rd_count + 1, 20, "bp_read");
    push_byte(8'h22, 8'h22);
    wr_b = wr_count;
    rd_b = rd_count;
    repeat (20) step();
    check("bp_no_write", 32'(wr_count), 32'(wr_b));
    check("bp_no_read", 32'(rd_count), 32'(rd_b));
    tx_q_full = 1'b0;
    step();
    check("bp_release_write", 32'(wr_count), 32'(wr_b + 1));
    wait_writes(wr_b + 2, 20, "bp_second");
    step();
    check("bp_cnt", 32'(echo_cnt0), 32'(n_pushed));
    check("bp_last", 32'({last0, last1}), 32'({8'h22, 8'h22}));

    // Burst of four queued bytes
    repeat (3) step();
    wr_cyc_q.delete();
    wr_b = wr_count;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i), 8'(8'h10 + i));
    wait_writes(wr_b + 4, 40, "burst_done");
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check("burst_gap", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd3);
    step();
    check("burst_cnt", 32'(echo_cnt0), 32'(n_pushed));
    check("burst_last", 32'(last0), 32'h13);

    // Case-swap table
    for (int i = 0; i < 12; i++) begin
      wr_b = wr_count;
      push_byte(tbl[i].in_b, tbl[i].exp_sw);
      wait_writes(wr_b + 1, 20, "tbl_done");
      step();
      check("tbl_plain", 32'(last0), 32'(tbl[i].in_b));
      check("tbl_swap", 32'(last1), 32'(tbl[i].exp_sw));
    end

    // Random traffic with random TX back-pressure
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        push_byte(b, swap_ref(b));
      end
      tx_q_full = ($urandom_range(0, 2) == 0);
      step();
    end
    tx_q_full = 1'b0;
    wait_writes(n_pushed, 3000, "rand_drain");
    step();
    check("rand_cnt", 32'({echo_cnt0, echo_cnt1}), 32'({16'(n_pushed), 16'(n_pushed)}));
    check("rand_queues_empty", 32'(rx_q.size() + exp_q0.size() + exp_q1.size()), 32'd0);

    // Reset while a byte is held
    tx_q_full = 1'b1;
    push_byte(8'h77, 8'h77);
    wait_reads(rd_count + 1, 20, "rst_read");
    step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bus", 32'({bus0.iocs_n, bus0.iorw_n, bus0.ioaddr, bus0.io_wdata}), 32'({4'b1100, 8'h00}));
    check("midrst_bus_swapdut", 32'({bus1.iocs_n, bus1.iorw_n, bus1.ioaddr, bus1.io_wdata}), 32'({4'b1100, 8'h00}));
    check("midrst_outs", 32'({init_done0, echo_cnt0, last0}), 32'd0);
    check("midrst_outs_swapdut", 32'({init_done1, echo_cnt1, last1}), 32'd0);
    rx_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    tx_q_full = 1'b0;
    wr_b = wr_count;
    repeat (2) step();
    rst_n = 1'b1;
    check_init();
    repeat (10) step();
    check("midrst_no_write", 32'(wr_count), 32'(wr_b));
    check("midrst_cnt", 32'(echo_cnt0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
